// File: rtl/systolic_skew_feeder_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Definitions shared by the skew feeder and the FP32 systolic MAC array:
//   FP32_W     - width of one FP32 element on a lane
//   N_DEFAULT  - default array edge
//   state_t    - feeder state encoding (IDLE/LOAD/STREAM/DRAIN)
//   lane_slice - bit offset of lane/element idx inside a packed N*FP32_W bus
// -----------------------------------------------------------------------------
package systolic_pkg;

  localparam int FP32_W    = 32;
  localparam int N_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  function automatic int lane_slice(input int idx);
    return idx * FP32_W;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_lane_mux.sv
// -----------------------------------------------------------------------------
// skew_lane_mux
// Element selector for one skewed lane. Given the N candidate elements of the
// lane (a row of A for a data lane, a column of B for a weight lane) and the
// current beat t, it drives element k = t - LANE when 0 <= k < N, else zero
// with valid low.
// Ports:
//   i_elems  [N*FP32_W]  candidate elements, element k at lane_slice(k)
//   i_t      [TW]        current stream beat
//   o_data   [FP32_W]    selected element or 0
//   o_valid  [1]         high when an element is selected
// -----------------------------------------------------------------------------
module skew_lane_mux
  import systolic_pkg::*;
#(
  parameter int N    = N_DEFAULT,
  parameter int LANE = 0,
  parameter int TW   = 5
) (
  input  logic [N*FP32_W-1:0] i_elems,
  input  logic [TW-1:0]       i_t,
  output logic [FP32_W-1:0]   o_data,
  output logic                o_valid
);

  // Compare against every k instead of subtracting, so no out-of-range
  // index is ever formed for beats before or after this lane's window.
  always_comb begin
    o_data  = '0;
    o_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (int'(i_t) == LANE + k) begin
        o_data  = i_elems[lane_slice(k) +: FP32_W];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// systolic_skew_feeder
// Buffers an N x N data matrix A and weight matrix B (row-wise valid/ready),
// then drives them into the systolic array as diagonally skewed lanes,
// followed by DRAIN all-valid zero beats. One matrix pair per start.
// Ports:
//   clk, rstn (async, active-low)
//   i_start                    start pulse, honoured in IDLE only
//   i_a_row/i_a_valid/o_a_ready  A rows 0..N-1, element k at [k*32 +: 32]
//   i_b_row/i_b_valid/o_b_ready  B rows 0..N-1, same packing
//   i_stall                    freezes stream/drain progress, gates valids
//   o_left_d_bus/o_left_d_v    data lane i at [i*32 +: 32] and its valid
//   o_top_w_bus/o_top_w_v      weight lane j at [j*32 +: 32] and its valid
//   o_busy                     high while a run is in progress
//   o_done                     pulse with the final drain beat
// All outputs are registered.
// -----------------------------------------------------------------------------
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int DRAIN = N + 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_start,
  input  logic [N*FP32_W-1:0] i_a_row,
  input  logic                i_a_valid,
  output logic                o_a_ready,
  input  logic [N*FP32_W-1:0] i_b_row,
  input  logic                i_b_valid,
  output logic                o_b_ready,
  input  logic                i_stall,
  output logic [N*FP32_W-1:0] o_left_d_bus,
  output logic [N-1:0]        o_left_d_v,
  output logic [N*FP32_W-1:0] o_top_w_bus,
  output logic [N-1:0]        o_top_w_v,
  output logic                o_busy,
  output logic                o_done
);

  localparam int CW = $clog2(N) + 1;
  localparam int IW = $clog2(N);
  localparam int TW = $clog2(2 * N + DRAIN);
  localparam logic [CW-1:0] CNT_FULL      = CW'(N);
  localparam logic [TW-1:0] T_STREAM_LAST = TW'(2 * N - 2);
  localparam logic [TW-1:0] T_DRAIN_LAST  = TW'(DRAIN - 1);

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_a_cnt, r_b_cnt, w_a_cnt_nxt, w_b_cnt_nxt;
  logic [TW-1:0]       r_t, w_t_nxt;
  logic                w_stream_beat, w_drain_beat, w_done_nxt;
  logic                w_a_acc, w_b_acc;

  logic [N*FP32_W-1:0] r_a_buf [N];
  logic [N*FP32_W-1:0] r_b_buf [N];
  logic [N*FP32_W-1:0] w_b_col [N];
  logic [N*FP32_W-1:0] w_d_data, w_w_data;
  logic [N-1:0]        w_d_v, w_w_v;

  logic [N*FP32_W-1:0] r_d_bus, r_w_bus;
  logic [N-1:0]        r_d_v, r_w_v;
  logic                r_a_ready, r_b_ready, r_busy, r_done;

  // Ready is only ever high in LOAD with room left, so this is the full accept.
  assign w_a_acc = i_a_valid & r_a_ready;
  assign w_b_acc = i_b_valid & r_b_ready;

  always_ff @(posedge clk) begin
    if (w_a_acc) r_a_buf[r_a_cnt[IW-1:0]] <= i_a_row;
    if (w_b_acc) r_b_buf[r_b_cnt[IW-1:0]] <= i_b_row;
  end

  // Weight lane j walks down column j of B, so transpose for the lane muxes.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      w_b_col[j] = '0;
      for (int k = 0; k < N; k++) begin
        w_b_col[j][lane_slice(k) +: FP32_W] = r_b_buf[k][lane_slice(j) +: FP32_W];
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    skew_lane_mux #(.N(N), .LANE(g), .TW(TW)) u_d_mux (
      .i_elems (r_a_buf[g]),
      .i_t     (r_t),
      .o_data  (w_d_data[lane_slice(g) +: FP32_W]),
      .o_valid (w_d_v[g])
    );
    skew_lane_mux #(.N(N), .LANE(g), .TW(TW)) u_w_mux (
      .i_elems (w_b_col[g]),
      .i_t     (r_t),
      .o_data  (w_w_data[lane_slice(g) +: FP32_W]),
      .o_valid (w_w_v[g])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_a_cnt <= '0;
      r_b_cnt <= '0;
      r_t     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_a_cnt <= w_a_cnt_nxt;
      r_b_cnt <= w_b_cnt_nxt;
      r_t     <= w_t_nxt;
    end
  end

  // r_t is the stream beat in STREAM and is reused as the drain beat in DRAIN.
  always_comb begin
    w_state_nxt   = r_state;
    w_a_cnt_nxt   = r_a_cnt;
    w_b_cnt_nxt   = r_b_cnt;
    w_t_nxt       = r_t;
    w_stream_beat = 1'b0;
    w_drain_beat  = 1'b0;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = ST_LOAD;
          w_a_cnt_nxt = '0;
          w_b_cnt_nxt = '0;
        end
      end
      ST_LOAD: begin
        if (w_a_acc) w_a_cnt_nxt = r_a_cnt + 1'b1;
        if (w_b_acc) w_b_cnt_nxt = r_b_cnt + 1'b1;
        if (r_a_cnt == CNT_FULL && r_b_cnt == CNT_FULL) begin
          w_state_nxt = ST_STREAM;
          w_t_nxt     = '0;
        end
      end
      ST_STREAM: begin
        if (!i_stall) begin
          w_stream_beat = 1'b1;
          if (r_t == T_STREAM_LAST) begin
            w_state_nxt = ST_DRAIN;
            w_t_nxt     = '0;
          end else begin
            w_t_nxt = r_t + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!i_stall) begin
          w_drain_beat = 1'b1;
          if (r_t == T_DRAIN_LAST) begin
            w_state_nxt = ST_IDLE;
            w_t_nxt     = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_t_nxt = r_t + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output register: readies follow the next state so a handshake is never
  // accepted past the last row; busy stays up through the done cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_d_bus   <= '0;
      r_w_bus   <= '0;
      r_d_v     <= '0;
      r_w_v     <= '0;
      r_a_ready <= 1'b0;
      r_b_ready <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_a_ready <= (w_state_nxt == ST_LOAD) && (w_a_cnt_nxt < CNT_FULL);
      r_b_ready <= (w_state_nxt == ST_LOAD) && (w_b_cnt_nxt < CNT_FULL);
      r_busy    <= (w_state_nxt != ST_IDLE) || w_done_nxt;
      r_done    <= w_done_nxt;
      if (w_stream_beat) begin
        r_d_bus <= w_d_data;
        r_w_bus <= w_w_data;
        r_d_v   <= w_d_v;
        r_w_v   <= w_w_v;
      end else if (w_drain_beat) begin
        r_d_bus <= '0;
        r_w_bus <= '0;
        r_d_v   <= '1;
        r_w_v   <= '1;
      end else begin
        // Stalled or idle: data holds, valids drop so the array does not advance.
        r_d_v <= '0;
        r_w_v <= '0;
      end
    end
  end

  assign o_a_ready    = r_a_ready;
  assign o_b_ready    = r_b_ready;
  assign o_left_d_bus = r_d_bus;
  assign o_left_d_v   = r_d_v;
  assign o_top_w_bus  = r_w_bus;
  assign o_top_w_v    = r_w_v;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_skew_feeder
// Scoreboard bench for systolic_skew_feeder (N=8). Each run loads A and B,
// queues the expected skewed + drain beats computed from the matrices, and a
// monitor pops/compares every beat the DUT presents. Directed checks cover
// reset values, ready timing, latency, stall, ignored start and mid-run reset.
// -----------------------------------------------------------------------------
module tb_systolic_skew_feeder;

  localparam int N     = 8;
  localparam int DRAIN = N + 1;
  localparam int W     = N * 32;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         i_start = 1'b0;
  logic [W-1:0] i_a_row = '0;
  logic         i_a_valid = 1'b0;
  logic [W-1:0] i_b_row = '0;
  logic         i_b_valid = 1'b0;
  logic         i_stall = 1'b0;
  logic         o_a_ready, o_b_ready, o_busy, o_done;
  logic [W-1:0] o_left_d_bus, o_top_w_bus;
  logic [N-1:0] o_left_d_v, o_top_w_v;

  systolic_skew_feeder #(.N(N), .DRAIN(DRAIN)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_start      (i_start),
    .i_a_row      (i_a_row),
    .i_a_valid    (i_a_valid),
    .o_a_ready    (o_a_ready),
    .i_b_row      (i_b_row),
    .i_b_valid    (i_b_valid),
    .o_b_ready    (o_b_ready),
    .i_stall      (i_stall),
    .o_left_d_bus (o_left_d_bus),
    .o_left_d_v   (o_left_d_v),
    .o_top_w_bus  (o_top_w_bus),
    .o_top_w_v    (o_top_w_v),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic [N-1:0] dv;
    logic [W-1:0] w;
    logic [N-1:0] wv;
    logic         done;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  logic [31:0] A [N][N];
  logic [31:0] B [N][N];
  logic [W-1:0] last_d = '0;
  logic [W-1:0] last_w = '0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fp32_of_int(input int v);
    int e;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    e = 0;
    for (int b = 0; b < 31; b++) if (v[b]) e = b;
    m = 32'(v) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic logic [W-1:0] row_of(input bit is_b, input int r);
    logic [W-1:0] v;
    for (int k = 0; k < N; k++) v[k*32 +: 32] = is_b ? B[r][k] : A[r][k];
    return v;
  endfunction

  task automatic fill_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        A[r][c] = $urandom;
        B[r][c] = $urandom;
      end
  endtask

  // Reference: data lane i carries A[i][t-i], weight lane j carries B[t-j][j]
  // for beats t = 0..2N-2, then DRAIN zero beats with every lane valid.
  task automatic push_expected();
    beat_t e;
    for (int t = 0; t <= 2 * N - 2; t++) begin
      e.d = '0; e.w = '0; e.dv = '0; e.wv = '0; e.done = 1'b0;
      for (int l = 0; l < N; l++) begin
        if (t - l >= 0 && t - l < N) begin
          e.d[l*32 +: 32] = A[l][t-l];
          e.dv[l]         = 1'b1;
          e.w[l*32 +: 32] = B[t-l][l];
          e.wv[l]         = 1'b1;
        end
      end
      exp_q.push_back(e);
    end
    for (int d = 0; d < DRAIN; d++) begin
      e.d = '0; e.w = '0; e.dv = '1; e.wv = '1;
      e.done = (d == DRAIN - 1);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: any valid lane means a beat; otherwise data must hold.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        last_d = '0;
        last_w = '0;
      end else if (o_left_d_v != '0 || o_top_w_v != '0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got d_v=%h w_v=%h with nothing expected", o_left_d_v, o_top_w_v);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_d_bus", o_left_d_bus, mon_e.d);
          chk("beat_d_v", W'(o_left_d_v), W'(mon_e.dv));
          chk("beat_w_bus", o_top_w_bus, mon_e.w);
          chk("beat_w_v", W'(o_top_w_v), W'(mon_e.wv));
          chk("beat_done", W'(o_done), W'(mon_e.done));
        end
        last_d = o_left_d_bus;
        last_w = o_top_w_bus;
      end else begin
        chk("hold_d_bus", o_left_d_bus, last_d);
        chk("hold_w_bus", o_top_w_bus, last_w);
        chk("done_without_beat", W'(o_done), W'(1'b0));
      end
    end
  end

  // mode 0: both streams with random valid; mode 1: A toggles, B back-to-back.
  task automatic do_load(input int mode);
    int ai = 0;
    int bi = 0;
    int cyc = 0;
    bit af, bf;
    while ((ai < N || bi < N) && cyc < 300) begin
      if (ai < N) begin
        i_a_valid = (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
        i_a_row   = row_of(1'b0, ai);
      end else i_a_valid = 1'b0;
      if (bi < N) begin
        i_b_valid = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        i_b_row   = row_of(1'b1, bi);
      end else i_b_valid = 1'b0;
      af = i_a_valid && o_a_ready;
      bf = i_b_valid && o_b_ready;
      step();
      cyc++;
      if (af) begin
        ai++;
        if (ai == N) chk("a_ready_drop", W'(o_a_ready), W'(1'b0));
      end
      if (bf) begin
        bi++;
        if (bi == N) chk("b_ready_drop", W'(o_b_ready), W'(1'b0));
      end
    end
    i_a_valid = 1'b0;
    i_b_valid = 1'b0;
    if (ai < N || bi < N) begin
      n_checks++;
      n_fail++;
      $display("FAIL load_timeout: got a_rows=%0d b_rows=%0d required %0d each", ai, bi, N);
    end
  endtask

  // stall_mode 0: none, 1: beats 5..7 held off, 2: random.
  task automatic run(input int load_mode, input int stall_mode, input bit start_mid, input int reset_at);
    int beats, cyc, scnt;
    bit st, sp, sent, done_seen;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("a_ready_after_start", W'(o_a_ready), W'(1'b1));
    chk("b_ready_after_start", W'(o_b_ready), W'(1'b1));
    chk("busy_after_start", W'(o_busy), W'(1'b1));
    do_load(load_mode);
    push_expected();
    step();
    chk("no_beat_at_transition", W'({o_left_d_v, o_top_w_v}), W'(0));
    step();
    chk("first_beat_latency", W'({o_left_d_v[0], o_top_w_v[0]}), W'(2'b11));
    beats = 1; cyc = 0; scnt = 0; sent = 0; done_seen = 0;
    while (!done_seen && cyc < 400) begin
      if (reset_at >= 0 && beats == reset_at) begin
        rstn = 1'b0;
        #1;
        chk("rst_d_bus", o_left_d_bus, '0);
        chk("rst_w_bus", o_top_w_bus, '0);
        chk("rst_valids", W'({o_left_d_v, o_top_w_v}), W'(0));
        chk("rst_ctrl", W'({o_a_ready, o_b_ready, o_busy, o_done}), W'(0));
        exp_q.delete();
        i_stall = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
        chk("busy_after_reset", W'(o_busy), W'(1'b0));
        return;
      end
      st = 1'b0;
      if (stall_mode == 1 && beats == 5 && scnt < 3) st = 1'b1;
      if (stall_mode == 2) st = ($urandom_range(0, 3) == 0);
      if (st) scnt++;
      i_stall = st;
      sp = start_mid && beats == 3 && !sent;
      if (sp) sent = 1'b1;
      i_start = sp;
      step();
      cyc++;
      i_start = 1'b0;
      if (st) chk("stall_gates_valid", W'({o_left_d_v, o_top_w_v}), W'(0));
      else begin
        chk("beat_present", W'({o_left_d_v, o_top_w_v} != '0), W'(1'b1));
        beats++;
      end
      chk("busy_in_run", W'(o_busy), W'(1'b1));
      if (sp) chk("start_ignored", W'({o_a_ready, o_b_ready}), W'(0));
      if (o_done) begin
        done_seen = 1'b1;
        chk("done_beat_index", W'(beats), W'(3 * N));
      end
    end
    i_stall = 1'b0;
    if (!done_seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, required one after %0d beats", cyc, 3 * N);
    end
    step();
    chk("busy_after_done", W'(o_busy), W'(1'b0));
    chk("done_one_cycle", W'(o_done), W'(1'b0));
    chk("queue_drained", W'(exp_q.size()), W'(0));
  endtask

  initial begin
    #2;
    chk("rst_d_bus", o_left_d_bus, '0);
    chk("rst_w_bus", o_top_w_bus, '0);
    chk("rst_valids", W'({o_left_d_v, o_top_w_v}), W'(0));
    chk("rst_ctrl", W'({o_a_ready, o_b_ready, o_busy, o_done}), W'(0));
    step();
    step();
    rstn = 1'b1;
    step();
    chk("idle_ctrl", W'({o_a_ready, o_b_ready, o_busy, o_done}), W'(0));

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        A[r][c] = fp32_of_int(r * 8 + c);
        B[r][c] = (r == c) ? 32'h3F80_0000 : 32'h0;
      end
    run(0, 0, 1'b0, -1);

    fill_random(); run(0, 0, 1'b0, -1);
    fill_random(); run(1, 0, 1'b0, -1);
    fill_random(); run(0, 1, 1'b0, -1);
    fill_random(); run(0, 0, 1'b1, -1);
    fill_random(); run(0, 0, 1'b0, 10);
    fill_random(); run(0, 2, 1'b0, -1);
    fill_random(); run(1, 2, 1'b0, -1);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
